// File: rtl/bubble_host_sequencer_if.sv
// Bubble host sequencer handshake/bus interface.
// Groups the sequencer's control inputs and timing outputs so the core and
// its host connect through a single port.
//   master : host side  -- drives START/MODE/PAGES, observes status/strobes
//   slave  : sequencer  -- samples START/MODE/PAGES, drives status/strobes
// Signals:
//   START    one-cycle sequence request
//   MODE     00 boot+pages, 01 boot only, 10 pages only, 11 as 00
//   PAGES    number of pages (latched on an accepted START)
//   nBSEN    bubble shift enable, active low
//   nREPEN   replicator enable, active low
//   nBOOTEN  boot loop enable, active low
//   BUSY     sequence in progress
//   DONE     one-cycle end-of-sequence pulse
//   PAGE     current/last page index
interface bubble_host_sequencer_if #(
  parameter int unsigned PAGE_W = 11
);
  logic              START;
  logic [1:0]        MODE;
  logic [PAGE_W-1:0] PAGES;
  logic              nBSEN;
  logic              nREPEN;
  logic              nBOOTEN;
  logic              BUSY;
  logic              DONE;
  logic [PAGE_W-1:0] PAGE;

  modport master (
    output START, MODE, PAGES,
    input  nBSEN, nREPEN, nBOOTEN, BUSY, DONE, PAGE
  );

  modport slave (
    input  START, MODE, PAGES,
    output nBSEN, nREPEN, nBOOTEN, BUSY, DONE, PAGE
  );
endinterface

// File: rtl/bubble_host_sequencer.sv
// Bubble memory host sequencer.
// Generates the nBSEN / nREPEN / nBOOTEN timing for a boot-loop read followed
// by a number of page shifts. One timing counter, cleared on every state
// entry; every output is a register updated together with the state.
// Ports:
//   MCLK  sole clock, rising edge
//   RST   asynchronous active-high reset
//   bus   bubble_host_sequencer_if.slave (START/MODE/PAGES in,
//         nBSEN/nREPEN/nBOOTEN/BUSY/DONE/PAGE out)
// Build option:
//   BUBBLE_HOST_SEQ_LOOP_EN  when defined, FIN pulses DONE and restarts the
//                            sequence (PAGE cleared, BUSY held) until RST.
module bubble_host_sequencer #(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned PAGE_W     = 11,
  parameter int unsigned BOOT_DLY   = 25000,
  parameter int unsigned BOOT_LEN   = 2193872,
  parameter int unsigned BOOT_TAIL  = 211,
  parameter int unsigned REP_OFFSET = 19,
  parameter int unsigned REP_LOW    = 343,
  parameter int unsigned REP_HIGH   = 617,
  parameter int unsigned PAGE_GAP   = 37500,
  parameter int unsigned PAGE_LEN   = 337830
) (
  input logic                     MCLK,
  input logic                     RST,
  bubble_host_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOOT_DLY,
    S_BOOT_SHIFT,
    S_BOOT_TAIL,
    S_PAGE_GAP,
    S_PAGE_SHIFT,
    S_FIN
  } state_t;

  // Terminal counts (last counter value of each timed state).
  localparam logic [CNT_W-1:0] L_DLY_TC   = CNT_W'(BOOT_DLY - 1);
  localparam logic [CNT_W-1:0] L_BLEN_TC  = CNT_W'(BOOT_LEN - 1);
  localparam logic [CNT_W-1:0] L_TAIL_TC  = CNT_W'(BOOT_TAIL - 1);
  localparam logic [CNT_W-1:0] L_GAP_TC   = CNT_W'(PAGE_GAP - 1);
  localparam logic [CNT_W-1:0] L_PLEN_TC  = CNT_W'(PAGE_LEN - 1);
  localparam logic [CNT_W-1:0] L_REP_LOW  = CNT_W'(REP_LOW);
  localparam logic [CNT_W-1:0] L_REP_HIGH = CNT_W'(REP_HIGH);

  // nREPEN level and next toggle point on shift entry (counter = 0).
  localparam logic             L_REP_LVL0  = (REP_OFFSET == 0) ? 1'b0 : 1'b1;
  localparam logic [CNT_W-1:0] L_REP_EDGE0 = (REP_OFFSET == 0) ? L_REP_LOW
                                                               : CNT_W'(REP_OFFSET);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_rep_edge;  // counter value at which nREPEN next toggles
  logic              r_rep_stop;  // page shift: single pulse already issued
  logic [1:0]        r_mode;
  logic [PAGE_W-1:0] r_pages;
  logic [PAGE_W-1:0] r_page;
  logic              r_nbsen;
  logic              r_nrepen;
  logic              r_nbooten;
  logic              r_busy;
  logic              r_done;

  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_rep_hit;
  logic              w_more_pages;

  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_rep_hit    = !r_rep_stop && (w_cnt_inc == r_rep_edge);
  assign w_more_pages = ({1'b0, r_page} + (PAGE_W + 1)'(1)) < {1'b0, r_pages};

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rep_edge <= '0;
      r_rep_stop <= 1'b0;
      r_mode     <= '0;
      r_pages    <= '0;
      r_page     <= '0;
      r_nbsen    <= 1'b1;
      r_nrepen   <= 1'b1;
      r_nbooten  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.START) begin
            r_mode  <= bus.MODE;
            r_pages <= bus.PAGES;
            r_page  <= '0;
            r_busy  <= 1'b1;
            if (bus.MODE == 2'b10) begin
              r_state <= S_PAGE_GAP;
            end else begin
              r_state   <= S_BOOT_DLY;
              r_nbooten <= 1'b0;
            end
          end
        end

        S_BOOT_DLY: begin
          if (r_cnt == L_DLY_TC) begin
            r_state    <= S_BOOT_SHIFT;
            r_cnt      <= '0;
            r_nbsen    <= 1'b0;
            r_nrepen   <= L_REP_LVL0;
            r_rep_edge <= L_REP_EDGE0;
            r_rep_stop <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_BOOT_SHIFT: begin
          if (r_cnt == L_BLEN_TC) begin
            // nREPEN released with nBSEN even if a pulse is cut short.
            r_state  <= S_BOOT_TAIL;
            r_cnt    <= '0;
            r_nbsen  <= 1'b1;
            r_nrepen <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_rep_hit) begin
              r_nrepen   <= ~r_nrepen;
              r_rep_edge <= r_rep_edge + (r_nrepen ? L_REP_LOW : L_REP_HIGH);
            end
          end
        end

        S_BOOT_TAIL: begin
          if (r_cnt == L_TAIL_TC) begin
            r_cnt     <= '0;
            r_nbooten <= 1'b1;
            if (r_mode == 2'b01) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_PAGE_GAP;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_PAGE_GAP: begin
          if (r_pages == '0) begin
            r_state <= S_FIN;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end else if (r_cnt == L_GAP_TC) begin
            r_state    <= S_PAGE_SHIFT;
            r_cnt      <= '0;
            r_nbsen    <= 1'b0;
            r_nrepen   <= L_REP_LVL0;
            r_rep_edge <= L_REP_EDGE0;
            r_rep_stop <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_PAGE_SHIFT: begin
          if (r_cnt == L_PLEN_TC) begin
            r_cnt    <= '0;
            r_nbsen  <= 1'b1;
            r_nrepen <= 1'b1;
            r_page   <= r_page + PAGE_W'(1);
            if (w_more_pages) begin
              r_state <= S_PAGE_GAP;
            end else begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_rep_hit) begin
              r_nrepen   <= ~r_nrepen;
              r_rep_edge <= r_rep_edge + L_REP_LOW;
              // Only one pulse per page: freeze toggling once it rises.
              if (!r_nrepen) begin
                r_rep_stop <= 1'b1;
              end
            end
          end
        end

        S_FIN: begin
          r_done <= 1'b0;
          r_cnt  <= '0;
`ifdef BUBBLE_HOST_SEQ_LOOP_EN
          r_page <= '0;
          if (r_mode == 2'b10) begin
            r_state <= S_PAGE_GAP;
          end else begin
            r_state   <= S_BOOT_DLY;
            r_nbooten <= 1'b0;
          end
`else
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`endif
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.nBSEN   = r_nbsen;
  assign bus.nREPEN  = r_nrepen;
  assign bus.nBOOTEN = r_nbooten;
  assign bus.BUSY    = r_busy;
  assign bus.DONE    = r_done;
  assign bus.PAGE    = r_page;

endmodule

// File: doc/bubble_host_sequencer.md
BUBBLE_HOST_SEQUENCER -- requirements
Module: bubble_host_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- CNT_W, 24, width of every timing counter.
- PAGE_W, 11, width of the page count and page index.
- BOOT_DLY, 25000, MCLK cycles from START to the first boot shift.
- BOOT_LEN, 2193872, boot-phase nBSEN-low length in cycles.
- BOOT_TAIL, 211, cycles from the boot nBSEN release to the nBOOTEN release.
- REP_OFFSET, 19, cycles from nBSEN fall to the first nREPEN fall.
- REP_LOW, 343, nREPEN low width in cycles.
- REP_HIGH, 617, nREPEN high width between boot pulses in cycles.
- PAGE_GAP, 37500, nBSEN-high cycles before each page shift.
- PAGE_LEN, 337830, page-phase nBSEN-low length in cycles.
REQ-002 Ports (name, direction, width, meaning), one per line:
- MCLK, in, 1, sole clock; all state updates on the rising edge.
- RST, in, 1, asynchronous active-high reset.
- START, in, 1, one-cycle request to begin a sequence.
- MODE, in, 2, 00 = boot then pages, 01 = boot only, 10 = pages only, 11 = treated as 00.
- PAGES, in, PAGE_W, number of pages; sampled on an accepted START.
- nBSEN, out, 1, bubble shift enable, active low.
- nREPEN, out, 1, replicator enable, active low.
- nBOOTEN, out, 1, boot loop enable, active low.
- BUSY, out, 1, high while the sequence is not IDLE.
- DONE, out, 1, one-cycle pulse at the end of the sequence.
- PAGE, out, PAGE_W, index of the current or last page; increments by one per page.

Function
REQ-003 States SHALL be IDLE, BOOT_DLY, BOOT_SHIFT, BOOT_TAIL, PAGE_GAP, PAGE_SHIFT and FIN, with a single CNT_W-bit counter that clears on every state entry.
REQ-004 START SHALL be accepted only in IDLE; START while BUSY is high SHALL be ignored.
REQ-005 An accepted START SHALL latch MODE and PAGES, clear PAGE, and move to BOOT_DLY (MODE 00, 01 or 11) or to PAGE_GAP (MODE 10) on the next edge.
REQ-006 nBOOTEN SHALL be 0 from entry to BOOT_DLY until BOOT_TAIL completes, and 1 at all other times.
REQ-007 BOOT_DLY SHALL last BOOT_DLY cycles with nBSEN=1, then go to BOOT_SHIFT.
REQ-008 BOOT_SHIFT SHALL hold nBSEN=0 for exactly BOOT_LEN cycles.
REQ-009 In BOOT_SHIFT, nREPEN SHALL first fall at counter value REP_OFFSET, then alternate REP_LOW cycles low and REP_HIGH cycles high.
REQ-010 nREPEN SHALL be forced to 1 on the cycle nBSEN rises, even if that truncates a pulse.
REQ-011 BOOT_TAIL SHALL last BOOT_TAIL cycles with nBSEN=1, then release nBOOTEN and go to PAGE_GAP (MODE 00 or 11) or to FIN (MODE 01).
REQ-012 PAGE_GAP SHALL last PAGE_GAP cycles with nBSEN=1; if the latched PAGES is 0 it SHALL go to FIN immediately instead.
REQ-013 PAGE_SHIFT SHALL hold nBSEN=0 for PAGE_LEN cycles and issue exactly one nREPEN low pulse of REP_LOW cycles starting at counter value REP_OFFSET.
REQ-014 On PAGE_SHIFT exit, PAGE SHALL increment; the sequence SHALL return to PAGE_GAP while PAGE+1 < PAGES, otherwise go to FIN.
REQ-015 FIN SHALL assert DONE for one cycle, deassert BUSY on the same edge it is left, and return to IDLE.
REQ-016 Every output SHALL be registered, with no combinational path from inputs to outputs, and every transition SHALL occur exactly one cycle after its terminal count.

Reset
REQ-017 RST high SHALL, asynchronously and at any point mid-sequence, force: state IDLE, counter 0, nBSEN=1, nREPEN=1, nBOOTEN=1, BUSY=0, DONE=0, PAGE=0.
REQ-018 Release of RST SHALL take effect on the next MCLK edge; no glitch SHALL occur on nBSEN or nREPEN.

Configuration
REQ-019 With BUBBLE_HOST_SEQ_LOOP_EN defined, FIN SHALL pulse DONE and then re-enter BOOT_DLY (or PAGE_GAP for MODE 10) with PAGE cleared, repeating until RST; BUSY SHALL stay 1.
REQ-020 Without BUBBLE_HOST_SEQ_LOOP_EN, the sequence SHALL run once and return to IDLE.

Verification
REQ-021 Use parameters BOOT_DLY=10, BOOT_LEN=100, BOOT_TAIL=5, REP_OFFSET=3, REP_LOW=4, REP_HIGH=6, PAGE_GAP=8, PAGE_LEN=20 for all of the following:
- MODE=01, START -> nBSEN low exactly 100 cycles starting 10 cycles after START; nREPEN falls at offsets 3, 13, 23 ... 93; nBOOTEN rises 5 cycles after nBSEN rises; then DONE.
- MODE=10, PAGES=3 -> three 20-cycle nBSEN lows, each preceded by 8 high cycles; one 4-cycle nREPEN pulse at offset 3 in each; PAGE ends at 3; DONE after the third page.
- MODE=10, PAGES=0 -> DONE within 3 cycles of START; nBSEN never low.
- START repeated mid-BOOT_SHIFT -> ignored, timing unchanged; RST asserted mid-PAGE_SHIFT -> all outputs at reset values in the same cycle, BUSY=0.
- BUBBLE_HOST_SEQ_LOOP_EN defined, MODE=00, PAGES=1 -> DONE pulses periodically, BUSY stays 1, and the nBOOTEN low phase recurs each loop.
